// File: rtl/in_channel_fifo_if.sv
// Producer/core-facing signal bundle of the input channel FIFO.
// The master side is the producer plus core; the slave side is the FIFO itself.
interface in_channel_fifo_if #(
   parameter int MemoryElementWidth = 12,
   parameter int CountWidth         = 12
);
   logic                          load_valid;
   logic [MemoryElementWidth-1:0] load_data;
   logic                          load_ready;
   logic                          pop;
   logic [MemoryElementWidth-1:0] pop_data;
   logic                          pop_valid;
   logic [CountWidth-1:0]         size;
   logic                          empty;
   logic [CountWidth-1:0]         consumed;
   logic                          underflow;

   modport master (
      output load_valid, load_data, pop,
      input  load_ready, pop_data, pop_valid, size, empty, consumed, underflow
   );

   modport slave (
      input  load_valid, load_data, pop,
      output load_ready, pop_data, pop_valid, size, empty, consumed, underflow
   );
endinterface

// File: rtl/in_channel_fifo.sv
// Circular-buffer input channel feeding the execution core: producer pushes over
// valid/ready, the core pops one word per "in" and reads the held count.
module in_channel_fifo #(
   parameter int MemoryElementWidth = 12,
   parameter int NIn                = 3,
   parameter int CountWidth         = 12
) (
   input logic               clock,
   input logic               run,
   in_channel_fifo_if.slave  ch
);
   localparam int PtrW = (NIn > 1) ? $clog2(NIn) : 1;
   localparam int CntW = $clog2(NIn + 1);

   typedef logic [PtrW-1:0]               ptr_t;
   typedef logic [CntW-1:0]               cnt_t;
   typedef logic [MemoryElementWidth-1:0] word_t;

   word_t                 mem_q [NIn];
   ptr_t                  rd_ptr_q, rd_ptr_d;
   ptr_t                  wr_ptr_q, wr_ptr_d;
   cnt_t                  count_q, count_d;
   word_t                 pop_data_q, pop_data_d;
   logic                  pop_valid_q, pop_valid_d;
   logic [CountWidth-1:0] consumed_q, consumed_d;
   logic                  underflow_q, underflow_d;
   logic                  push, pop_ok;

   // Explicit wrap so a non-power-of-2 depth never indexes past NIn-1.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(NIn - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   assign ch.load_ready = (count_q != cnt_t'(NIn));
   assign ch.empty      = (count_q == '0);
   assign ch.size       = CountWidth'(count_q);
   assign ch.pop_data   = pop_data_q;
   assign ch.pop_valid  = pop_valid_q;
   assign ch.consumed   = consumed_q;
   assign ch.underflow  = underflow_q;

   assign push   = ch.load_valid && ch.load_ready;
   assign pop_ok = ch.pop && !ch.empty;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = 1'b0;
      consumed_d  = consumed_q;
      underflow_d = underflow_q;

      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);

      if (pop_ok) begin
         rd_ptr_d    = ptr_inc(rd_ptr_q);
         pop_data_d  = mem_q[rd_ptr_q];
         pop_valid_d = 1'b1;
         consumed_d  = consumed_q + CountWidth'(1);
      end else if (ch.pop) begin
         underflow_d = 1'b1;
      end

      case ({push, pop_ok})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all update together at the edge.
   always_ff @(posedge clock or negedge run) begin
      if (!run) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
         consumed_q  <= '0;
         underflow_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
         consumed_q  <= consumed_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: storage is deliberately not reset; count gates every read, so stale words are never seen.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= ch.load_data;
   end
endmodule

// File: tb/tb_in_channel_fifo.sv
// Directed and randomised checks of in_channel_fifo with depth 3.
module tb_in_channel_fifo;
   localparam int W  = 12;
   localparam int N  = 3;
   localparam int CW = 12;

   logic clock = 1'b0;
   logic run   = 1'b0;
   int   total = 0;
   int   bad   = 0;

   in_channel_fifo_if #(.MemoryElementWidth(W), .CountWidth(CW)) ch ();

   in_channel_fifo #(.MemoryElementWidth(W), .NIn(N), .CountWidth(CW)) dut (
      .clock (clock),
      .run   (run),
      .ch    (ch)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      ch.load_valid = 1'b0;
      ch.load_data  = '0;
      ch.pop        = 1'b0;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " load_ready"}, int'(ch.load_ready), 1);
      chk({tag, " empty"},      int'(ch.empty),      1);
      chk({tag, " size"},       int'(ch.size),       0);
      chk({tag, " pop_data"},   int'(ch.pop_data),   0);
      chk({tag, " pop_valid"},  int'(ch.pop_valid),  0);
      chk({tag, " consumed"},   int'(ch.consumed),   0);
      chk({tag, " underflow"},  int'(ch.underflow),  0);
   endtask

   task automatic test_reset();
      idle();
      run = 1'b0;
      step();
      step();
      chk_reset_state("reset");
      run = 1'b1;
      step();
   endtask

   task automatic push_word(input int v);
      ch.load_valid = 1'b1;
      ch.load_data  = W'(v);
      step();
      ch.load_valid = 1'b0;
   endtask

   task automatic test_fill_drain();
      int vals[3] = '{33, 22, 11};
      for (int i = 0; i < 3; i++) begin
         chk("fill load_ready before push", int'(ch.load_ready), 1);
         push_word(vals[i]);
         chk("fill size", int'(ch.size), i + 1);
      end
      chk("fill load_ready full", int'(ch.load_ready), 0);
      ch.pop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("drain pop_valid", int'(ch.pop_valid), 1);
         chk("drain pop_data", int'(ch.pop_data), vals[i]);
         chk("drain size", int'(ch.size), 2 - i);
      end
      ch.pop = 1'b0;
      step();
      chk("drain pop_valid low", int'(ch.pop_valid), 0);
      chk("drain empty", int'(ch.empty), 1);
      chk("drain consumed", int'(ch.consumed), 3);
   endtask

   task automatic test_underflow();
      ch.pop = 1'b1;
      step();
      ch.pop = 1'b0;
      chk("uflow underflow", int'(ch.underflow), 1);
      chk("uflow pop_valid", int'(ch.pop_valid), 0);
      chk("uflow pop_data held", int'(ch.pop_data), 11);
      chk("uflow size", int'(ch.size), 0);
      chk("uflow consumed", int'(ch.consumed), 3);
      step();
      step();
      chk("uflow sticky", int'(ch.underflow), 1);
      run = 1'b0;
      step();
      chk("uflow cleared by reset", int'(ch.underflow), 0);
      run = 1'b1;
      step();
   endtask

   task automatic test_full_push_pop();
      int exp[3] = '{22, 11, 44};
      push_word(33);
      push_word(22);
      push_word(11);
      chk("fullpp size full", int'(ch.size), 3);
      ch.pop        = 1'b1;
      ch.load_valid = 1'b1;
      ch.load_data  = W'(44);
      step();
      chk("fullpp pop_data", int'(ch.pop_data), 33);
      chk("fullpp size after", int'(ch.size), 2);
      ch.pop = 1'b0;
      step();
      ch.load_valid = 1'b0;
      chk("fullpp size refill", int'(ch.size), 3);
      ch.pop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fullpp drain data", int'(ch.pop_data), exp[i]);
      end
      ch.pop = 1'b0;
      step();
      chk("fullpp empty", int'(ch.empty), 1);
   endtask

   task automatic test_back_to_back();
      push_word(1);
      for (int v = 2; v <= 10; v++) begin
         ch.load_valid = 1'b1;
         ch.load_data  = W'(v);
         ch.pop        = 1'b1;
         step();
         chk("b2b pop_valid", int'(ch.pop_valid), 1);
         chk("b2b pop_data", int'(ch.pop_data), v - 1);
         chk("b2b size", int'(ch.size), 1);
      end
      ch.load_valid = 1'b0;
      step();
      chk("b2b last data", int'(ch.pop_data), 10);
      chk("b2b empty", int'(ch.empty), 1);
      ch.pop = 1'b0;
      step();
      chk("b2b underflow clear", int'(ch.underflow), 0);
   endtask

   task automatic test_async_reset();
      push_word(5);
      push_word(6);
      chk("areset size before", int'(ch.size), 2);
      #2;
      run = 1'b0;
      #1;
      chk_reset_state("areset");
      #3;
      run = 1'b1;
      step();
      chk("areset size after release", int'(ch.size), 0);
   endtask

   task automatic test_random();
      int q[$];
      int exp_data;
      int exp_cons = 0;
      bit exp_uf   = 1'b0;
      bit lv, pp, do_push, do_pop;
      int d;
      for (int c = 0; c < 1000; c++) begin
         lv = 1'($urandom_range(0, 1));
         pp = 1'($urandom_range(0, 1));
         d  = int'($urandom_range(0, 4095));
         ch.load_valid = lv;
         ch.load_data  = W'(d);
         ch.pop        = pp;
         #1;
         chk("rand load_ready", int'(ch.load_ready), (q.size() != N) ? 1 : 0);
         do_push = lv && (q.size() != N);
         do_pop  = pp && (q.size() != 0);
         if (do_pop) begin
            exp_data = q.pop_front();
            exp_cons++;
         end else if (pp) begin
            exp_uf = 1'b1;
         end
         if (do_push) q.push_back(d);
         step();
         chk("rand pop_valid", int'(ch.pop_valid), do_pop ? 1 : 0);
         if (do_pop) chk("rand pop_data", int'(ch.pop_data), exp_data);
         chk("rand size", int'(ch.size), q.size());
         chk("rand consumed", int'(ch.consumed), exp_cons);
         chk("rand underflow", int'(ch.underflow), exp_uf ? 1 : 0);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_underflow();
      test_full_push_pop();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
